uart_tx_fsm: RTL and testbench

UART transmitter that serialises one parallel byte per frame onto a single line. Frame order is start bit, data bits LSB first, optional parity bit, then one stop bit. It is the transmit-side counterpart of the receiver FSM, and its frame format matches that receiver: idle-high line, 8 data bits, parity, stop. It sits between the host-side byte interface (valid/ready handshake) and the serial pin, and holds each bit for a programmable number of clock cycles.

---
 rtl/uart_tx_fsm.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_fsm.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm
//
// UART transmitter. Serialises one parallel word per frame onto an
// idle-high line in this order: start bit, data bits LSB first, an
// optional parity bit, and one stop bit. Each bit is held for
// CLKS_PER_BIT clock cycles. The frame format matches the companion
// receiver FSM.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   DATA_BITS     data bits per frame (5..8)
//   PARITY_EN     1 = insert a parity bit after the data bits
//   PARITY_ODD    1 = odd parity, 0 = even parity (ignored if PARITY_EN=0)
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   tx_data   word to send, sampled only on the handshake edge
//   tx_valid  host has a word to send
//   tx_ready  transmitter can accept a word (high only while idle)
//   tx        registered serial line, idles high
//   tx_busy   a frame is in progress
//   tx_done   one-cycle pulse in the first idle cycle after the stop bit
module uart_tx_fsm #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic              PAR_ON    = (PARITY_EN != 0);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Parity over the whole word; odd parity is the inverse of even parity.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PAR_ODD;
  endfunction

  // Control state (reset)
  logic [2:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic              tx_q;
  logic              done_q;

  // Frame payload (not reset; only meaningful after a handshake)
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_q;

  // Next-state values
  logic [2:0]        state_nxt;
  logic [BAUD_W-1:0] baud_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic              tx_nxt;
  logic              done_nxt;
  logic              shift_en;

  logic accept;
  logic bit_end;

  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);
  assign tx       = tx_q;
  assign tx_done  = done_q;

  assign accept  = tx_valid && tx_ready;
  assign bit_end = (state != IDLE) && (baud_cnt == BAUD_LAST);

  // The line level is computed for the state being entered and registered
  // together with it, so tx changes exactly on bit boundaries with no
  // combinational path to the pin. In DATA the next bit is shift_reg[1]
  // because the shift happens on the same edge.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt + BAUD_ONE;
    idx_nxt   = bit_idx;
    tx_nxt    = tx_q;
    done_nxt  = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        tx_nxt   = 1'b1;
        if (accept) begin
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          baud_nxt  = '0;
          idx_nxt   = '0;
          tx_nxt    = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          shift_en = 1'b1;
          if (bit_idx == IDX_LAST) begin
            if (PAR_ON) begin
              state_nxt = PARITY;
              tx_nxt    = parity_q;
            end else begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            idx_nxt = bit_idx + IDX_ONE;
            tx_nxt  = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          baud_nxt  = '0;
          tx_nxt    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          baud_nxt  = '0;
          tx_nxt    = 1'b1;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  // Control register stage: a reset mid-frame abandons the frame at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= idx_nxt;
      tx_q     <= tx_nxt;
      done_q   <= done_nxt;
    end
  end

  // Payload register stage: the word is captured only on the handshake,
  // so later tx_data changes cannot disturb the frame in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_reg <= tx_data;
      parity_q  <= calc_parity(tx_data);
    end else if (shift_en) begin
      shift_reg <= shift_reg >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm. Three instances with CLKS_PER_BIT=4:
// [0] even parity, [1] odd parity, [2] no parity.
module tb_uart_tx_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] valid;
  logic [7:0] data [3];
  wire  [2:0] txl;
  wire  [2:0] rdy;
  wire  [2:0] busy;
  wire  [2:0] done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_fsm #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .reset(reset), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx_fsm #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .reset(reset), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  uart_tx_fsm #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
    .clk(clk), .reset(reset), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // At a negedge: unit u must be idle, then present word d with valid high.
  task automatic begin_frame(input int u, input logic [7:0] d);
    @(negedge clk);
    chk($sformatf("u%0d ready_idle", u), rdy[u], 1);
    chk($sformatf("u%0d done_clear", u), done[u], 0);
    data[u]  = d;
    valid[u] = 1'b1;
  endtask

  // Handshake edge, then every cycle of an nbits frame (exp: first bit is
  // bit nbits-1), then the tx_done cycle. tx_data is changed to alt
  // mid-frame; hold keeps tx_valid high for a back-to-back frame.
  task automatic frame(input int u, input int nbits, input logic [15:0] exp,
                       input logic hold, input logic [7:0] alt);
    @(posedge clk);
    for (int k = 0; k < nbits * 4; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) valid[u] = 1'b0;
      if (k == 10) data[u] = alt;
      chk($sformatf("u%0d bit%0d cyc%0d tx", u, k / 4, k % 4), txl[u], exp[nbits-1-k/4]);
      chk($sformatf("u%0d cyc%0d ready", u, k), rdy[u], 0);
      chk($sformatf("u%0d cyc%0d busy", u, k), busy[u], 1);
      chk($sformatf("u%0d cyc%0d done", u, k), done[u], 0);
    end
    @(negedge clk);
    chk($sformatf("u%0d done_pulse", u), done[u], 1);
    chk($sformatf("u%0d ready_after", u), rdy[u], 1);
    chk($sformatf("u%0d tx_idle_gap", u), txl[u], 1);
    chk($sformatf("u%0d busy_after", u), busy[u], 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset   = 1'b0;
    valid   = 3'b000;
    data[0] = 8'h00;
    data[1] = 8'h00;
    data[2] = 8'h00;
    #12;
    chk("reset tx", txl[0], 1);
    chk("reset ready", rdy[0], 1);
    chk("reset busy", busy[0], 0);
    chk("reset done", done[0], 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
    begin_frame(0, 8'hA5);
    frame(0, 11, 16'b01010010101, 1'b0, 8'h00);

    // 0x00 odd parity: data 0, parity 1
    begin_frame(1, 8'h00);
    frame(1, 11, 16'b00000000011, 1'b0, 8'hFF);

    // 0xFF even parity: data 1, parity 0
    begin_frame(0, 8'hFF);
    frame(0, 11, 16'b01111111101, 1'b0, 8'h00);

    // 0x3C no parity: 0,0,0,1,1,1,1,0,0,1
    begin_frame(2, 8'h3C);
    frame(2, 10, 16'b0001111001, 1'b0, 8'hFF);

    // Back-to-back: 0x55 then 0xAA with valid held, data changed mid-frame
    begin_frame(0, 8'h55);
    frame(0, 11, 16'b01010101001, 1'b1, 8'hAA);
    frame(0, 11, 16'b00101010101, 1'b0, 8'h12);

    // Reset during data bit 3 (frame cycles 16..19)
    begin_frame(0, 8'hC3);
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_reset busy", busy[0], 1);
    reset = 1'b0;
    #1;
    chk("mid_reset tx", txl[0], 1);
    chk("mid_reset busy", busy[0], 0);
    chk("mid_reset ready", rdy[0], 1);
    chk("mid_reset done", done[0], 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("in_reset%0d tx", i), txl[0], 1);
      chk($sformatf("in_reset%0d done", i), done[0], 0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset tx", txl[0], 1);
    chk("post_reset ready", rdy[0], 1);
    chk("post_reset busy", busy[0], 0);
    chk("post_reset done", done[0], 0);

    // 0x81 even parity: 0,1,0,0,0,0,0,0,1,0,1
    begin_frame(0, 8'h81);
    frame(0, 11, 16'b01000000101, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
